// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Brief    : Shared helpers and state encoding for the panel input/display blocks.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps

package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } bar_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Codes are zero-extended to 64 bits so one helper serves every bar width.
    function automatic int popcount(input logic [63:0] code);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(code[i]);
        end
        return n;
    endfunction

    // 0...01...1 (including all-zero) has no set bit above a clear bit.
    function automatic logic is_thermometer(input logic [63:0] code);
        return ((code & (code + 64'd1)) == 64'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for asynchronous panel inputs.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

`default_nettype wire

// File: rtl/bar_decoder.sv
`default_nettype none
// ============================================================================
// Module   : bar_decoder
// Brief    : Debounced thermometer-bar to binary level decoder with bubble flag.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps

module bar_decoder
    import display_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int OUT_WIDTH     = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  bar_in,
    output logic [OUT_WIDTH-1:0] level,
    output logic                 valid,
    output logic                 bubble
);

    localparam int               c_CNT_W    = clog2(STABLE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);

    logic [IN_WIDTH-1:0]  w_s2;
    bar_state_t           r_state;
    bar_state_t           w_state_nxt;
    logic [IN_WIDTH-1:0]  r_cand;
    logic [IN_WIDTH-1:0]  w_cand_nxt;
    logic [IN_WIDTH-1:0]  r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_accept;
    logic [OUT_WIDTH-1:0] w_popcnt;
    logic                 w_bubble;
    logic [OUT_WIDTH-1:0] r_level;
    logic                 r_valid;
    logic                 r_bubble;

    sync_2ff #(
        .WIDTH (IN_WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bar_in),
        .o_q (w_s2)
    );

    assign w_popcnt = OUT_WIDTH'(popcount(64'(r_cand)));
    assign w_bubble = ~is_thermometer(64'(r_cand));

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (en) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_cand_nxt  = w_s2;
                w_cnt_nxt   = '0;
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (!en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_s2 != r_cand) begin
                    w_cand_nxt = w_s2;
                    w_cnt_nxt  = '0;
                end else if (r_cnt < c_CNT_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    // A code equal to the accepted one qualifies silently.
                    w_accept    = (r_cand != r_acc);
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_s2 != r_cand) begin
                    w_cand_nxt  = w_s2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cand   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_bubble <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_accept;
            if (w_accept) begin
                r_acc    <= r_cand;
                r_level  <= w_popcnt;
                r_bubble <= w_bubble;
            end
        end
    end

    assign level  = r_level;
    assign valid  = r_valid;
    assign bubble = r_bubble;

endmodule

`default_nettype wire

// File: doc/bar_decoder.md
# bar_decoder

Inverse of the LED bar driver: samples an asynchronous thermometer-coded bar input (slider switch bank, comparator ladder, level-sensor strip), synchronises it, requires a stable reading for a programmable number of cycles, and emits the bar's fill level as an unsigned binary count with a one-cycle strobe. Non-thermometer codes ("bubbles") are still counted and also flagged. It sits between the front-panel or sensor pins and any consumer that needs a binary level.

## Interface
- IN_WIDTH, 8: number of bar elements sampled.
- OUT_WIDTH, 4: width of level output; must satisfy 2^OUT_WIDTH > IN_WIDTH.
- STABLE_CYCLES, 4: confirmation cycles a code must hold before acceptance; minimum 1.
- clk  input  1  system clock.
- rst  input  1  system reset; asynchronous, active-high.
- en  input  1  qualify enable; 0 freezes outputs and suspends acceptance.
- bar_in  input  IN_WIDTH  raw bar code, asynchronous to clk; bit 0 is the lowest element.
- level  output  OUT_WIDTH  number of set bits in the last accepted code.
- valid  output  1  one-cycle strobe: level and bubble were just updated.
- bubble  output  1  last accepted code was not of the form 0…01…1.

## Operation
- bar_in passes through a two-flop synchroniser (s1, s2); s2 is the sampled code.
- Registers: cand (candidate code), acc (accepted code), cnt (confirmation counter, width clog2(STABLE_CYCLES)+1).
- FSM states:
  - IDLE: en=0; cnt held at 0; no acceptance. On en=1 -> LOAD.
  - LOAD: cand<=s2, cnt<=0 -> SETTLE.
  - SETTLE: if en=0 -> IDLE. If s2!=cand -> cand<=s2, cnt<=0, stay. Else if cnt<STABLE_CYCLES-1 -> cnt++. Else (cnt==STABLE_CYCLES-1, s2==cand): if cand!=acc -> accept; -> HOLD.
  - HOLD: if en=0 -> IDLE. If s2!=cand -> cand<=s2, cnt<=0 -> SETTLE. Otherwise stay, no strobe.
- Accept: acc<=cand, level<=popcount(cand), bubble<=(cand not thermometer), valid<=1 for exactly one cycle.
- Equal-to-accepted codes (e.g. a glitch that returns to the old value) complete qualification without a strobe.
- popcount counts all set bits; a bubbled code reports its set-bit count, not its MSB index.
- level and bubble hold their value between strobes, including while en=0.

## Timing
- Reset (async assert): s1, s2, cand, acc, cnt = 0; FSM = IDLE; level=0, valid=0, bubble=0. Release is taken synchronously by the design flops; no strobe results from an all-zero bar after reset.
- Latency, en held 1 and FSM in SETTLE/HOLD: new bar_in captured by rising edge 1; s2 at edge 2; cand loaded at edge 3; accept at edge STABLE_CYCLES+3; valid high for the cycle following that edge (edge 7 for default).
- Any s2 change during SETTLE restarts the count; the edge count above restarts from the change.
- en falling on the accept edge: accept does not occur; no strobe.
- en rising: LOAD on next edge, then full STABLE_CYCLES qualification, even if s2 equals previous cand.
- Reset mid-qualification: all state discarded, outputs to reset values immediately.
- Back-to-back accepts separated by at least STABLE_CYCLES+1 cycles; valid never high two consecutive cycles.

## Structure
- Shared package display_pkg: clog2 function, popcount function, is_thermometer function, FSM state encoding constants (IDLE, LOAD, SETTLE, HOLD).
- Sub-module sync_2ff (parameterised width, async active-high reset) for the synchroniser; reused by other panel-input blocks.
- Popcount is combinational on cand; register only at accept.

## Test plan
- Reset with bar_in=8'h00, en=1, hold 20 cycles -> level=0, valid never asserts, bubble=0.
- en=1, bar_in 8'h00 -> 8'h1F held -> valid one cycle at edge 7 after change, level=5, bubble=0.
- bar_in=8'h0F, toggling to 8'h07 every 3 cycles for 30 cycles, then steady 8'h07 -> no strobe during toggling; one strobe, level=3, after 7 edges of steady value.
- Accepted 8'h03, apply 8'h0B (bubble) steady -> valid, level=3, bubble=1; then 8'h0F -> valid, level=4, bubble=0.
- Accepted 8'h01, apply 8'hFF, drop en at edge 5 for 4 cycles, raise en -> no strobe while en=0; strobe level=8 exactly STABLE_CYCLES+2 edges after en rises.
- Assert rst asynchronously (mid-cycle) during SETTLE with cnt=2 -> level, valid, bubble at 0 before next edge; no strobe for 8'h00 after release.
